// File: rtl/fft_pkg.sv
// Shared defaults, hand-over state encoding and helpers for the FFT sample buffer.
package fft_pkg;

    localparam int FFT_POINTS_DEFAULT = 512;
    localparam int DATA_WIDTH_DEFAULT = 24;
    localparam int OVR_CNT_WIDTH      = 8;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        LOCKED  = 2'd2
    } buf_state_e;

    // Saturating increment so a long stall never wraps the drop counter.
    function automatic logic [OVR_CNT_WIDTH-1:0] sat_inc(input logic [OVR_CNT_WIDTH-1:0] v);
        return (v == {OVR_CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/sample_bank_ram.sv
// Two-bank sample storage: one synchronous write port, one asynchronous read port.
module sample_bank_ram
    import fft_pkg::*;
#(
    parameter int DEPTH      = 2 * FFT_POINTS_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // No reset on the array: contents are undefined until the first frame lands.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fft_sample_buffer.sv
// Ping-pong frame buffer between a free-running sample stream and an FFT controller.
module fft_sample_buffer
    import fft_pkg::*;
#(
    parameter int FFT_POINTS = FFT_POINTS_DEFAULT,
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
    localparam int AW        = $clog2(FFT_POINTS)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_sample_valid,
    input  logic [DATA_WIDTH-1:0]    i_sample_data,
    output logic                     o_data_ready,
    input  logic [AW-1:0]            i_buffer_read_addr,
    output logic [DATA_WIDTH-1:0]    o_buffer_data_out,
    input  logic                     i_fft_busy,
    output logic                     o_overrun,
    output logic [OVR_CNT_WIDTH-1:0] o_overrun_count
);

    buf_state_e    state, state_nxt;
    logic          wr_bank;
    logic [AW-1:0] wr_idx;
    logic          frame_done;
    logic          bank_toggle;
    logic          frame_drop;

    assign frame_done = i_sample_valid && (wr_idx == AW'(FFT_POINTS - 1));

    // Evaluated on the registered state, so a frame finishing on the
    // LOCKED->FREE cycle is still dropped.
    always_comb begin
        state_nxt   = state;
        bank_toggle = 1'b0;
        frame_drop  = 1'b0;
        case (state)
            FREE: begin
                if (frame_done) begin
                    bank_toggle = 1'b1;
                    state_nxt   = PENDING;
                end
            end
            PENDING: begin
                frame_drop = frame_done;
                if (i_fft_busy) state_nxt = LOCKED;
            end
            LOCKED: begin
                frame_drop = frame_done;
                if (!i_fft_busy) state_nxt = FREE;
            end
            default: state_nxt = FREE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= FREE;
            wr_bank         <= 1'b0;
            wr_idx          <= '0;
            o_overrun       <= 1'b0;
            o_overrun_count <= '0;
        end else begin
            state     <= state_nxt;
            wr_bank   <= wr_bank ^ bank_toggle;
            o_overrun <= frame_drop;
            if (i_sample_valid) wr_idx <= wr_idx + 1'b1;
            if (frame_drop) o_overrun_count <= sat_inc(o_overrun_count);
        end
    end

    assign o_data_ready = (state == PENDING);

    sample_bank_ram #(
        .DEPTH      (2 * FFT_POINTS),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (AW + 1)
    ) u_ram (
        .clk     (clk),
        .we      (i_sample_valid),
        .wr_addr ({wr_bank, wr_idx}),
        .wr_data (i_sample_data),
        .rd_addr ({~wr_bank, i_buffer_read_addr}),
        .rd_data (o_buffer_data_out)
    );

endmodule

// File: tb/tb_fft_sample_buffer.sv
// Directed bench for fft_sample_buffer with 8-point frames.
module tb_fft_sample_buffer;

    localparam int N  = 8;
    localparam int DW = 24;

    logic          clk;
    logic          reset;
    logic          i_sample_valid;
    logic [DW-1:0] i_sample_data;
    logic          o_data_ready;
    logic [2:0]    i_buffer_read_addr;
    logic [DW-1:0] o_buffer_data_out;
    logic          i_fft_busy;
    logic          o_overrun;
    logic [7:0]    o_overrun_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          valid;
        logic [DW-1:0] data;
        logic          busy;
        logic          exp_ready;
        logic          exp_ovr;
        logic [7:0]    exp_cnt;
    } vec_t;

    vec_t vecs [26];

    fft_sample_buffer #(.FFT_POINTS(N), .DATA_WIDTH(DW)) dut (
        .clk                (clk),
        .reset              (reset),
        .i_sample_valid     (i_sample_valid),
        .i_sample_data      (i_sample_data),
        .o_data_ready       (o_data_ready),
        .i_buffer_read_addr (i_buffer_read_addr),
        .o_buffer_data_out  (o_buffer_data_out),
        .i_fft_busy         (i_fft_busy),
        .o_overrun          (o_overrun),
        .o_overrun_count    (o_overrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        i_sample_valid = 1'b1;
        i_sample_data  = v;
        @(negedge clk);
        i_sample_valid = 1'b0;
    endtask

    task automatic read_frame(input string name, input int base);
        for (int a = 0; a < N; a++) begin
            i_buffer_read_addr = 3'(a);
            #1;
            check(name, 32'(o_buffer_data_out), 32'(base + a));
            @(negedge clk);
        end
    endtask

    task automatic apply(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            i_sample_valid = vecs[i].valid;
            i_sample_data  = vecs[i].data;
            i_fft_busy     = vecs[i].busy;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 32'(o_data_ready), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d_ovr", i), 32'(o_overrun), 32'(vecs[i].exp_ovr));
            check($sformatf("vec%0d_cnt", i), 32'(o_overrun_count), 32'(vecs[i].exp_cnt));
        end
        i_sample_valid = 1'b0;
    endtask

    initial begin
        int pulses;
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, DW'(i + 1), 1'b0, (i == 7), 1'b0, 8'd0};
        for (int i = 8; i < 16; i++)
            vecs[i] = '{1'b1, DW'(i + 1), 1'b1, 1'b0, (i == 15), (i == 15) ? 8'd1 : 8'd0};
        vecs[16] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[17] = '{1'b0, '0, 1'b0, 1'b0, 1'b0, 8'd1};
        for (int i = 18; i < 26; i++)
            vecs[i] = '{1'b1, DW'(i - 1), 1'b0, (i == 25), 1'b0, 8'd1};

        reset = 1'b0;
        i_sample_valid = 1'b0;
        i_sample_data = '0;
        i_fft_busy = 1'b0;
        i_buffer_read_addr = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(o_data_ready), 32'd0);
        check("rst_ovr", 32'(o_overrun), 32'd0);
        check("rst_cnt", 32'(o_overrun_count), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // First frame, acknowledge, overrun while locked, then release and refill.
        apply(0, 7);
        read_frame("rd_first", 1);
        apply(8, 11);
        read_frame("rd_locked", 1);
        apply(12, 16);
        read_frame("rd_after_ovr", 1);
        apply(17, 25);
        read_frame("rd_second", 17);

        // Reset in the middle of a frame discards the partial frame.
        for (int k = 0; k < 5; k++) push(DW'(50 + k));
        reset = 1'b0;
        #1;
        check("midrst_ready", 32'(o_data_ready), 32'd0);
        check("midrst_cnt", 32'(o_overrun_count), 32'd0);
        check("midrst_ovr", 32'(o_overrun), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            push(DW'(101 + k));
            check($sformatf("post_rst_ready%0d", k), 32'(o_data_ready), (k == N - 1) ? 32'd1 : 32'd0);
        end
        read_frame("rd_post_rst", 101);

        // Saturation of the drop counter.
        i_fft_busy = 1'b1;
        @(negedge clk);
        check("sat_locked_ready", 32'(o_data_ready), 32'd0);
        pulses = 0;
        for (int f = 0; f < 300; f++) begin
            for (int k = 0; k < N; k++) begin
                push(DW'(1000 + k));
                if (o_overrun) pulses++;
            end
            if (f == 0)   check("sat_cnt_first", 32'(o_overrun_count), 32'd1);
            if (f == 254) check("sat_cnt_255", 32'(o_overrun_count), 32'd255);
        end
        check("sat_cnt_final", 32'(o_overrun_count), 32'd255);
        check("sat_pulses", 32'(pulses), 32'd300);
        check("sat_ready", 32'(o_data_ready), 32'd0);
        read_frame("rd_sat", 101);

        // Frame finishing on the same cycle as the release still counts as a drop.
        for (int k = 0; k < N - 1; k++) push(DW'(2000 + k));
        i_fft_busy = 1'b0;
        push(DW'(2007));
        check("race_ovr", 32'(o_overrun), 32'd1);
        check("race_ready", 32'(o_data_ready), 32'd0);
        @(negedge clk);
        check("race_ovr_clear", 32'(o_overrun), 32'd0);
        check("race_free_ready", 32'(o_data_ready), 32'd0);
        for (int k = 0; k < N; k++) push(DW'(200 + k));
        check("race_next_ready", 32'(o_data_ready), 32'd1);
        read_frame("rd_race_next", 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
